// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen geometry, colour constants and plotter state encoding
package game_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int CELL     = 4;
    localparam int GRID_W   = SCREEN_W / CELL;
    localparam int GRID_H   = SCREEN_H / CELL;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] WHITE = 3'b111;

    localparam logic [2:0] BG_COLOUR      = BLACK;
    localparam logic [2:0] OUTLINE_COLOUR = WHITE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CELL,
        ST_CLEAR,
        ST_DONE
    } plot_state_t;

endpackage

// File: rtl/xy_scan_counter.sv
// rtl/xy_scan_counter.sv - reloadable 2-D raster counter (x inner, y outer) with last-pixel flag
module xy_scan_counter #(
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          en,
    input  logic [XW-1:0] width,
    input  logic [YW-1:0] height,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic [XW-1:0] w_lim;
    logic [YW-1:0] h_lim;
    logic          x_end;
    logic          y_end;

    assign x_end = (x == w_lim - 1'b1);
    assign y_end = (y == h_lim - 1'b1);
    assign last  = x_end && y_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x     <= '0;
            y     <= '0;
            w_lim <= '0;
            h_lim <= '0;
        end else if (load) begin
            x     <= '0;
            y     <= '0;
            w_lim <= width;
            h_lim <= height;
        end else if (en) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cell_plotter.sv
// rtl/cell_plotter.sv - expands cell draw requests and screen clears into vga_adapter pixel writes (optional CELL_OUTLINE_EN)
module cell_plotter
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_cell_x,
    input  logic [4:0] req_cell_y,
    input  logic [2:0] req_colour,
    input  logic       clear_req,
    output logic       busy,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam logic [7:0] CELL_W8 = 8'(CELL);
    localparam logic [6:0] CELL_H7 = 7'(CELL);
    localparam logic [7:0] SCR_W8  = 8'(SCREEN_W);
    localparam logic [6:0] SCR_H7  = 7'(SCREEN_H);
    localparam logic [6:0] GRID_W7 = 7'(GRID_W);
    localparam logic [5:0] GRID_H6 = 6'(GRID_H);

    plot_state_t state, state_next;
    logic        clear_pend;
    logic [7:0]  base_x;
    logic [6:0]  base_y;
    logic [2:0]  cell_colour;
    logic [2:0]  cell_pix;
    logic        take, in_range, load, load_screen, scan_last;
    logic [7:0]  scan_x, lim_w;
    logic [6:0]  scan_y, lim_h;

    assign in_range  = ({1'b0, req_cell_x} < GRID_W7) && ({1'b0, req_cell_y} < GRID_H6);
    assign req_ready = (state == ST_IDLE) && !clear_req;
    assign busy      = (state == ST_CELL) || (state == ST_CLEAR);
    assign done      = (state == ST_DONE);
    assign vga_plot  = busy;
    assign lim_w     = load_screen ? SCR_W8 : CELL_W8;
    assign lim_h     = load_screen ? SCR_H7 : CELL_H7;

    xy_scan_counter #(.XW(8), .YW(7)) u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .en      (busy),
        .width   (lim_w),
        .height  (lim_h),
        .x       (scan_x),
        .y       (scan_y),
        .last    (scan_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Out-of-range cells skip straight to DONE so the done pulse lands one cycle after transfer.
    always_comb begin
        state_next  = state;
        take        = 1'b0;
        load        = 1'b0;
        load_screen = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (clear_req) begin
                    state_next  = ST_CLEAR;
                    load        = 1'b1;
                    load_screen = 1'b1;
                end else if (req_valid) begin
                    take       = 1'b1;
                    load       = 1'b1;
                    state_next = in_range ? ST_CELL : ST_DONE;
                end
            end
            ST_CELL, ST_CLEAR: begin
                if (scan_last) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (clear_pend || clear_req) begin
                    state_next  = ST_CLEAR;
                    load        = 1'b1;
                    load_screen = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clear_pend  <= 1'b0;
            base_x      <= '0;
            base_y      <= '0;
            cell_colour <= '0;
        end else begin
            if (state_next == ST_CLEAR) begin
                clear_pend <= 1'b0;
            end else if ((state == ST_CELL) && clear_req) begin
                clear_pend <= 1'b1;
            end
            if (take) begin
                base_x      <= 8'(req_cell_x) * CELL_W8;
                base_y      <= 7'(req_cell_y) * CELL_H7;
                cell_colour <= req_colour;
            end
        end
    end

`ifdef CELL_OUTLINE_EN
    logic on_edge;
    assign on_edge  = (scan_x == '0) || (scan_x == CELL_W8 - 8'd1) ||
                      (scan_y == '0) || (scan_y == CELL_H7 - 7'd1);
    // Erasing with the background colour must not leave an outline behind.
    assign cell_pix = (on_edge && (cell_colour != BG_COLOUR)) ? OUTLINE_COLOUR : cell_colour;
`else
    assign cell_pix = cell_colour;
`endif

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        if (state == ST_CELL) begin
            vga_x      = base_x + scan_x;
            vga_y      = base_y + scan_y;
            vga_colour = cell_pix;
        end else if (state == ST_CLEAR) begin
            vga_x      = scan_x;
            vga_y      = scan_y;
            vga_colour = BG_COLOUR;
        end
    end

endmodule
